// File: rtl/fnn_pkg.sv
// Shared defaults and FSM encoding for the output-layer scoring logic.
package fnn_pkg;

    localparam int N_OUT_DEF     = 10;
    localparam int DW_DEF        = 8;
    localparam int N_SAMPLES_DEF = 750;
    localparam int CLS_W_DEF     = 4;
    localparam int CNT_W         = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        RESULT = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/en_counter.sv
// Enable-gated up counter with asynchronous reset; saturates instead of wrapping.
module en_counter
    import fnn_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/argmax_scorer.sv
// Scans one captured output-layer vector per request with a single reused comparator,
// reports the argmax class, whether it matches the label, and running score counters.
module argmax_scorer
    import fnn_pkg::*;
#(
    parameter int N_OUT     = N_OUT_DEF,
    parameter int DW        = DW_DEF,
    parameter int N_SAMPLES = N_SAMPLES_DEF,
    parameter int CLS_W     = CLS_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [N_OUT*DW-1:0]   vals,
    input  logic [CLS_W-1:0]      label,
    output logic                  busy,
    output logic                  valid,
    output logic [CLS_W-1:0]      pred,
    output logic                  eq,
    output logic [CNT_W-1:0]      sample_cnt,
    output logic [CNT_W-1:0]      correct_cnt,
    output logic                  all_done
);

    state_t state, next_state;

    logic [N_OUT*DW-1:0]   cap_vals;
    logic [CLS_W-1:0]      cap_label;
    logic [CLS_W-1:0]      idx;
    logic [CLS_W-1:0]      best_idx;
    logic signed [DW-1:0]  best_val;
    logic signed [DW-1:0]  cur_val;

    logic accept;
    logic greater;
    logic last_elem;
    logic final_sample;
    logic result_eq;
    logic count_en;

    // A start landing in the result-pulse cycle is dropped along with the RESULT-state one.
    assign accept       = (state == IDLE) && start && !valid;
    assign cur_val      = cap_vals[idx*DW +: DW];
    assign greater      = cur_val > best_val;
    assign last_elem    = (idx == CLS_W'(N_OUT - 1));
    assign final_sample = (sample_cnt == CNT_W'(N_SAMPLES - 1));
    assign result_eq    = (best_idx == cap_label) && (int'(cap_label) < N_OUT);
    assign count_en     = (state == RESULT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (accept) next_state = SCAN;
            SCAN:    if (last_elem) next_state = RESULT;
            RESULT:  next_state = final_sample ? DONE : IDLE;
            DONE:    next_state = DONE;
        endcase
    end

    // NOTE: the capture registers are plain flops, not a RAM, so they take the async reset too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_vals  <= '0;
            cap_label <= '0;
            idx       <= '0;
            best_idx  <= '0;
            best_val  <= '0;
            valid     <= 1'b0;
            pred      <= '0;
            eq        <= 1'b0;
        end else begin
            if (accept) begin
                cap_vals  <= vals;
                cap_label <= label;
                best_val  <= vals[DW-1:0];
                best_idx  <= '0;
                idx       <= CLS_W'(1);
            end else if (state == SCAN) begin
                // Strictly greater only, so ties keep the lowest index.
                if (greater) begin
                    best_val <= cur_val;
                    best_idx <= idx;
                end
                idx <= idx + CLS_W'(1);
            end

            valid <= (state == RESULT);
            if (state == RESULT) begin
                pred <= best_idx;
                eq   <= result_eq;
            end
        end
    end

    // Counters only step in RESULT, and DONE never returns there, so they freeze at N_SAMPLES.
    en_counter #(.W(CNT_W)) u_sample_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (count_en),
        .count (sample_cnt)
    );

    en_counter #(.W(CNT_W)) u_correct_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (count_en && result_eq),
        .count (correct_cnt)
    );

    assign busy     = (state == SCAN) || (state == RESULT) || valid;
    assign all_done = (state == DONE);

endmodule

// File: doc/argmax_scorer.md
ARGMAX_SCORER -- requirements
Module: argmax_scorer

Interface
REQ-001 Parameter N_OUT, 10, number of output-layer neurons scanned per sample.
REQ-002 Parameter DW, 8, width of each signed neuron value.
REQ-003 Parameter N_SAMPLES, 750, number of test samples per run.
REQ-004 Parameter CLS_W, 4, width of class index and label.
REQ-005 clk  in  1  clock; reset rst, asynchronous, active-high; clock clk.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 start  in  1  one-cycle request to score the current sample.
REQ-008 vals  in  N_OUT*DW  output-layer values, element i at bits [i*DW +: DW], two's complement.
REQ-009 label  in  CLS_W  expected class for the sample.
REQ-010 busy  out  1  high from the cycle after an accepted start through the result cycle.
REQ-011 valid  out  1  one-cycle pulse marking pred/eq updated.
REQ-012 pred  out  CLS_W  index of the maximum element.
REQ-013 eq  out  1  pred equals label.
REQ-014 sample_cnt  out  10  samples scored since reset.
REQ-015 correct_cnt  out  10  samples with eq=1 since reset.
REQ-016 all_done  out  1  high once sample_cnt reaches N_SAMPLES.

Function
REQ-017 FSM states IDLE, SCAN, RESULT, DONE; reset state IDLE.
REQ-018 IDLE: start=1 captures vals and label into internal registers, sets best_val=element 0, best_idx=0, idx=1, goes to SCAN.
REQ-019 start SHALL be ignored in SCAN, RESULT and DONE; captured vals/label SHALL NOT change during a scan.
REQ-020 SCAN: one element per cycle; element idx replaces best only if signed-strictly greater (ties keep lowest index); idx increments.
REQ-021 SCAN ends after element N_OUT-1 is compared (N_OUT-1 cycles), then RESULT.
REQ-022 RESULT (one cycle): pred=best_idx, eq=(best_idx==captured label), valid=1, sample_cnt+1, correct_cnt+eq.
REQ-023 Latency: start sampled at edge k -> valid high in the cycle following edge k+N_OUT (10 cycles for defaults).
REQ-024 A label >= N_OUT SHALL give eq=0.
REQ-025 pred and eq SHALL hold their values until the next RESULT.
REQ-026 After RESULT: if updated sample_cnt==N_SAMPLES go DONE, else IDLE; start in the RESULT cycle is dropped.
REQ-027 DONE: all_done=1, counters frozen, busy=0, remains until rst.
REQ-028 Counters SHALL never wrap; correct_cnt <= sample_cnt <= N_SAMPLES always.

Reset
REQ-029 rst at any time, including mid-SCAN, SHALL return to IDLE within the same cycle without emitting valid.
REQ-030 Reset values: busy=0, valid=0, pred=0, eq=0, sample_cnt=0, correct_cnt=0, all_done=0, internal capture registers 0.

Structure
REQ-031 Shared package fnn_pkg SHALL hold N_OUT, DW, N_SAMPLES, CLS_W defaults and the FSM state encoding.
REQ-032 One sub-module en_counter (enable-gated 10-bit up counter, async reset), instantiated for sample_cnt and correct_cnt.
REQ-033 Comparison SHALL be a single signed DW-bit comparator reused per cycle; no parallel comparator tree.

Verification
REQ-034 vals={e0..e9}={3,-5,7,1,0,7,-128,2,6,-1}, label=2, start -> valid 10 cycles later, pred=2 (tie with 5 keeps 2), eq=1, correct_cnt=1.
REQ-035 All elements -128 except e9=-127, label=0 -> pred=9, eq=0, sample_cnt=1, correct_cnt=0.
REQ-036 start re-pulsed at cycles 3 and 10 after first start -> both ignored; exactly one valid, sample_cnt=1.
REQ-037 rst asserted at cycle 5 of a scan -> no valid, all outputs at reset values, next start scores normally.
REQ-038 750 back-to-back samples, every 4th with correct label -> correct_cnt=188, sample_cnt=750, all_done=1; further start leaves counts unchanged.
REQ-039 label=12, max at index 4 -> pred=4, eq=0.
